axi_write_master: RTL and testbench
===================================

# axi_write_master

AXI4-Full write master for the DMA datapath. It drains 32-bit words from the read-to-write FIFO, which is filled by the read master, and writes them to a destination address as INCR bursts on the AW/W/B channels. Each burst is at most 64 bytes (16 beats) and never crosses a 4 KB boundary. It sits directly downstream of the read-side FIFO and reports completion to the DMA control block.

## Interface
- C_M_AXI_ID_WIDTH, 1: AXI ID width. AWID is driven 0.
- C_M_AXI_ADDR_WIDTH, 32: address width.
- C_M_AXI_DATA_WIDTH, 32: data width. Only 32 is supported.
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- i_start  in  1  start pulse; sampled only in IDLE
- i_dst_addr  in  32  destination byte address, word-aligned
- i_total_len  in  32  transfer length in bytes; bits [1:0] are ignored
- o_write_done  out  1  one-cycle completion pulse
- o_write_err  out  1  sticky error flag; set by any BRESP != OKAY, cleared on i_start
- o_busy  out  1  high whenever state != IDLE
- i_fifo_empty  in  1  FIFO empty flag
- i_fifo_data  in  32  FIFO head word (first-word-fall-through; valid when !i_fifo_empty)
- o_fifo_pop  out  1  pop strobe
- m_axi_awid  out  C_M_AXI_ID_WIDTH  constant 0
- m_axi_awaddr  out  C_M_AXI_ADDR_WIDTH  burst start address
- m_axi_awlen  out  8  beats minus 1
- m_axi_awsize  out  3  constant 3'b010
- m_axi_awburst  out  2  constant 2'b01 (INCR)
- m_axi_awvalid / m_axi_awready  out/in  1  AW handshake
- m_axi_wdata  out  C_M_AXI_DATA_WIDTH  equals i_fifo_data
- m_axi_wstrb  out  4  constant 4'hF
- m_axi_wlast  out  1  last beat of the burst
- m_axi_wvalid / m_axi_wready  out/in  1  W handshake
- m_axi_bresp  in  2  write response
- m_axi_bvalid / m_axi_bready  in/out  1  B handshake

## Operation
- **States:** IDLE, ADDR, DATA, RESP. One-hot encoded.
- **IDLE:**
  - On i_start, latch addr = i_dst_addr and rem = {i_total_len[31:2], 2'b00}, and clear o_write_err.
  - If rem == 0, pulse o_write_done on the next cycle and stay in IDLE; no AXI traffic is issued.
  - Otherwise go to ADDR.
- **Burst size:** bytes = min(rem, 64, 0x1000 - addr[11:0]). beats = bytes >> 2. awlen = beats - 1.
  - Computed from registered addr/rem, so it is stable while awvalid is high.
  - beats is latched into burst_beats on the AW handshake.
- **ADDR:**
  - awvalid is registered. It is set on the cycle the FSM enters ADDR and held until awready.
  - On handshake, clear awvalid, reset beat_cnt to 0, and go to DATA.
- **DATA:**
  - wvalid = !i_fifo_empty.
  - o_fifo_pop = wvalid & wready.
  - wlast = (beat_cnt == burst_beats - 1).
  - beat_cnt increments on each W handshake.
  - The W handshake with wlast moves the FSM to RESP.
- **RESP:**
  - bready = 1.
  - On bvalid:
    - If bresp != 2'b00, set o_write_err.
    - addr += burst_beats*4; rem -= burst_beats*4.
    - If the new rem == 0, pulse o_write_done and go to IDLE. Otherwise go to ADDR.
- **Error handling:** an error does not abort the transfer. All bursts are still issued.
- **Unsupported:** no outstanding AW beyond the current burst; no write interleaving.

## Timing
- **Reset values:** all outputs are 0 except the constants: awsize = 3'b010, awburst = 2'b01, wstrb = 4'hF. FSM is in IDLE.
- **Reset mid-burst:** the FSM returns immediately to IDLE and all valids drop asynchronously. Words already popped are lost.
- **Start latency:** i_start at cycle N gives awvalid high at cycle N+1.
- **Empty FIFO:** wvalid drops. beat_cnt and wlast hold until data arrives.
- **Pop ordering:** the pop takes effect in the same cycle as the W handshake. The FIFO presents the next word by the next cycle.
- **Ignored start:** i_start outside IDLE is ignored.
- **Done pulse:** o_write_done is exactly 1 cycle, registered, and asserted the cycle after the final B handshake.
- **Pipelining:** minimum of 1 idle cycle between a B handshake and the next awvalid.
- **Throughput:** back-to-back beats run at 1 beat/cycle when the FIFO is non-empty and wready = 1.

## Test plan
- **Single burst.** Stimulus: dst = 0x1000_0000, len = 64, FIFO pre-filled with 16 words, ready always high. Response:
  - One AW with awlen = 15.
  - 16 W beats with wlast only on beat 16.
  - o_write_done pulses once after bvalid.
- **Multi-burst.** Stimulus: len = 256, dst = 0x2000_0000. Response:
  - 4 AW at 0x2000_0000, 0x2000_0040, 0x2000_0080, 0x2000_00C0, each with awlen = 15.
  - Data order matches FIFO order.
- **4 KB crossing.** Stimulus: dst = 0x0000_0FF8, len = 32. Response:
  - AW at 0x0FF8 with awlen = 1.
  - Then AW at 0x1000 with awlen = 5.
  - 8 beats total.
- **FIFO stall.** Stimulus: len = 16, FIFO empty for 5 cycles after beat 2. Response:
  - wvalid is low during the gap.
  - beat_cnt and wlast are unchanged.
  - wlast is on the 4th beat.
  - 4 pops total.
- **Error.** Stimulus: bresp = SLVERR on burst 1 of 2 (len = 128). Response:
  - Burst 2 is still issued.
  - o_write_err = 1 at done.
  - o_write_err is cleared by the next i_start.
- **Zero length and reset.** Part 1: len = 0, expect o_write_done 1 cycle later with no awvalid. Part 2: reset_n low mid-DATA, expect all valids at 0 and o_busy = 0 immediately.

Source files
------------

// File: rtl/axi_write_master.sv
// AXI4 write master: drains 32-bit words from the read-to-write FIFO and writes
// them as INCR bursts of at most 16 beats that never cross a 4 KB boundary.
module axi_write_master #(
    parameter int C_M_AXI_ID_WIDTH   = 1,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          i_start,
    input  logic [31:0]                   i_dst_addr,
    input  logic [31:0]                   i_total_len,
    output logic                          o_write_done,
    output logic                          o_write_err,
    output logic                          o_busy,
    input  logic                          i_fifo_empty,
    input  logic [31:0]                   i_fifo_data,
    output logic                          o_fifo_pop,
    output logic [C_M_AXI_ID_WIDTH-1:0]   m_axi_awid,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]                    m_axi_awlen,
    output logic [2:0]                    m_axi_awsize,
    output logic [1:0]                    m_axi_awburst,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_wdata,
    output logic [3:0]                    m_axi_wstrb,
    output logic                          m_axi_wlast,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    input  logic [1:0]                    m_axi_bresp,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready
);

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        ADDR = 4'b0010,
        DATA = 4'b0100,
        RESP = 4'b1000
    } state_e;

    state_e                        state_q, state_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [29:0]                   rem_q, rem_d;          // remaining length in words
    logic                          awvalid_q, awvalid_d;
    logic [3:0]                    beat_cnt_q, beat_cnt_d;
    logic [4:0]                    burst_beats_q, burst_beats_d;
    logic                          done_q, done_d;
    logic                          err_q, err_d;

    logic [4:0]  cap_s;
    logic [10:0] bound_s;
    logic [4:0]  beats_s;
    logic [29:0] rem_new_s;
    logic        w_hs_s;
    logic        wlast_s;
    logic        unused_s;

    assign unused_s = ^i_total_len[1:0];

    // Burst length in words: limited by remaining length, 16 beats and the 4 KB page end.
    always_comb begin
        bound_s = 11'd1024 - {1'b0, addr_q[11:2]};
        if (rem_q < 30'd16) begin
            cap_s = rem_q[4:0];
        end else begin
            cap_s = 5'd16;
        end
        if (bound_s < {6'b000000, cap_s}) begin
            beats_s = bound_s[4:0];
        end else begin
            beats_s = cap_s;
        end
    end

    assign rem_new_s = rem_q - {25'b0, burst_beats_q};
    assign wlast_s   = (state_q == DATA) && ({1'b0, beat_cnt_q} == (burst_beats_q - 5'd1));
    assign w_hs_s    = m_axi_wvalid && m_axi_wready;

    // State register and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            rem_q         <= 30'd0;
            awvalid_q     <= 1'b0;
            beat_cnt_q    <= 4'd0;
            burst_beats_q <= 5'd0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            rem_q         <= rem_d;
            awvalid_q     <= awvalid_d;
            beat_cnt_q    <= beat_cnt_d;
            burst_beats_q <= burst_beats_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    // Next-state logic for the burst sequencer.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        rem_d         = rem_q;
        awvalid_d     = awvalid_q;
        beat_cnt_d    = beat_cnt_q;
        burst_beats_d = burst_beats_q;
        done_d        = 1'b0;
        err_d         = err_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    addr_d = C_M_AXI_ADDR_WIDTH'(i_dst_addr);
                    rem_d  = i_total_len[31:2];
                    err_d  = 1'b0;
                    if (i_total_len[31:2] == 30'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d   = ADDR;
                        awvalid_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ADDR: begin
                if (m_axi_awready) begin
                    awvalid_d     = 1'b0;
                    beat_cnt_d    = 4'd0;
                    burst_beats_d = beats_s;
                    state_d       = DATA;
                end else begin
                    awvalid_d = 1'b1;
                end
            end
            DATA: begin
                if (w_hs_s) begin
                    beat_cnt_d = beat_cnt_q + 4'd1;
                    if (wlast_s) begin
                        state_d = RESP;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    beat_cnt_d = beat_cnt_q;
                end
            end
            RESP: begin
                if (m_axi_bvalid) begin
                    if (m_axi_bresp != 2'b00) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                    addr_d = addr_q + C_M_AXI_ADDR_WIDTH'({burst_beats_q, 2'b00});
                    rem_d  = rem_new_s;
                    if (rem_new_s == 30'd0) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d   = ADDR;
                        awvalid_d = 1'b1;
                    end
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d   = IDLE;
                awvalid_d = 1'b0;
            end
        endcase
    end

    assign o_write_done  = done_q;
    assign o_write_err   = err_q;
    assign o_busy        = (state_q != IDLE);
    assign m_axi_awid    = '0;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = (beats_s == 5'd0) ? 8'd0 : {3'b000, beats_s - 5'd1};
    assign m_axi_awsize  = 3'b010;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awvalid = awvalid_q;
    // W follows the FIFO directly so beats stream at one per cycle.
    assign m_axi_wvalid  = (state_q == DATA) && !i_fifo_empty;
    assign m_axi_wdata   = i_fifo_data;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wlast   = wlast_s;
    assign o_fifo_pop    = w_hs_s;
    assign m_axi_bready  = (state_q == RESP);

endmodule

// File: tb/tb_axi_write_master.sv
// Scoreboard bench for axi_write_master: a FIFO/slave model drives the DUT and a
// negedge monitor compares every AW/W handshake and done pulse against a queue.
module tb_axi_write_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_start;
    logic [31:0] i_dst_addr, i_total_len;
    logic        o_write_done, o_write_err, o_busy;
    logic        i_fifo_empty;
    logic [31:0] i_fifo_data;
    logic        o_fifo_pop;
    logic [0:0]  m_axi_awid;
    logic [31:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awvalid, m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid, m_axi_bready;

    always #5 clk = ~clk;

    axi_write_master dut (
        .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_dst_addr(i_dst_addr),
        .i_total_len(i_total_len), .o_write_done(o_write_done), .o_write_err(o_write_err),
        .o_busy(o_busy), .i_fifo_empty(i_fifo_empty), .i_fifo_data(i_fifo_data),
        .o_fifo_pop(o_fifo_pop), .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr),
        .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata),
        .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [39:0] exp_aw[$];    // {awaddr, awlen}
    logic [32:0] exp_w[$];     // {wlast, wdata}
    logic        exp_done[$];  // expected o_write_err at the done pulse
    logic [31:0] fifo_q[$];

    bit rnd_mode  = 1'b0;
    int stall_at  = -1;
    int stall_cnt = 0;
    int pop_cnt   = 0;
    int b_pending = 0;
    int b_count   = 0;
    int err_burst = -1;
    int done_cnt  = 0;
    logic prev_done = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a handshake or done.
    always @(negedge clk) begin
        logic [39:0] ea;
        logic [32:0] ew;
        if (reset_n) begin
            if (m_axi_awvalid && m_axi_awready) begin
                if (exp_aw.size() == 0) chk("aw_unexpected", 64'd1, 64'd0);
                else begin
                    ea = exp_aw.pop_front();
                    chk("awaddr", 64'(m_axi_awaddr), 64'(ea[39:8]));
                    chk("awlen", 64'(m_axi_awlen), 64'(ea[7:0]));
                    chk("aw_consts", 64'({m_axi_awid, m_axi_awsize, m_axi_awburst}), 64'({1'b0, 3'b010, 2'b01}));
                end
            end
            if (m_axi_wvalid && m_axi_wready) begin
                if (exp_w.size() == 0) chk("w_unexpected", 64'd1, 64'd0);
                else begin
                    ew = exp_w.pop_front();
                    chk("wdata", 64'(m_axi_wdata), 64'(ew[31:0]));
                    chk("wlast", 64'(m_axi_wlast), 64'(ew[32]));
                    chk("wstrb", 64'(m_axi_wstrb), 64'hF);
                end
            end
            if (o_fifo_pop || (m_axi_wvalid && m_axi_wready))
                chk("pop_vs_hs", 64'(o_fifo_pop), 64'(m_axi_wvalid && m_axi_wready));
            if (o_busy && i_fifo_empty)
                chk("wvalid_gap", 64'(m_axi_wvalid), 64'd0);
            if (o_write_done) begin
                chk("done_width", 64'(prev_done), 64'd0);
                if (exp_done.size() == 0) chk("done_unexpected", 64'd1, 64'd0);
                else chk("write_err", 64'(o_write_err), 64'(exp_done.pop_front()));
                chk("aw_left", 64'(exp_aw.size()), 64'd0);
                chk("w_left", 64'(exp_w.size()), 64'd0);
                done_cnt++;
            end
            prev_done = o_write_done;
        end else begin
            prev_done = 1'b0;
        end
    end

    // FIFO and AXI slave model; inputs change only 1 ns after the rising edge.
    initial begin
        bit s_pop, s_wlast, s_b;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0;
        m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        i_fifo_empty = 1'b1; i_fifo_data = 32'h0;
        forever begin
            @(negedge clk);
            s_pop   = reset_n && o_fifo_pop;
            s_wlast = reset_n && m_axi_wvalid && m_axi_wready && m_axi_wlast;
            s_b     = reset_n && m_axi_bvalid && m_axi_bready;
            @(posedge clk);
            #1;
            if (stall_cnt > 0) stall_cnt--;
            if (s_pop && fifo_q.size() > 0) begin
                void'(fifo_q.pop_front());
                pop_cnt++;
                if (pop_cnt == stall_at) stall_cnt = 5;
            end
            if (s_wlast) b_pending++;
            if (s_b) begin
                m_axi_bvalid = 1'b0;
                b_count++;
            end
            if (!m_axi_bvalid && b_pending > 0 && (!rnd_mode || $urandom_range(0, 2) == 0)) begin
                m_axi_bvalid = 1'b1;
                m_axi_bresp  = (b_count == err_burst) ? 2'b10 : 2'b00;
                b_pending--;
            end
            i_fifo_empty  = (fifo_q.size() == 0) || (stall_cnt > 0) || (rnd_mode && $urandom_range(0, 4) == 0);
            i_fifo_data   = (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
            m_axi_awready = !rnd_mode || ($urandom_range(0, 1) == 1);
            m_axi_wready  = !rnd_mode || ($urandom_range(0, 3) != 0);
        end
    end

    // Reference model: split the transfer into bursts with plain arithmetic.
    task automatic load(input logic [31:0] dst, input logic [31:0] len, input int err_b);
        longint a = dst;
        longint r = len & 32'hFFFF_FFFC;
        longint bytes, to_pg;
        int nb = 0;
        logic [31:0] w;
        err_burst = err_b; pop_cnt = 0; b_count = 0; stall_cnt = 0;
        while (r > 0) begin
            bytes = (r > 64) ? 64 : r;
            to_pg = 4096 - (a % 4096);
            if (bytes > to_pg) bytes = to_pg;
            exp_aw.push_back({a[31:0], 8'(bytes / 4 - 1)});
            for (int i = 0; i < bytes / 4; i++) begin
                w = $urandom;
                fifo_q.push_back(w);
                exp_w.push_back({(i == bytes / 4 - 1), w});
            end
            a += bytes; r -= bytes; nb++;
        end
        exp_done.push_back(err_b >= 0 && err_b < nb);
    endtask

    task automatic start(input logic [31:0] dst, input logic [31:0] len);
        @(posedge clk); #1;
        i_dst_addr = dst; i_total_len = len; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        @(negedge clk);
        chk("start_awvalid", 64'(m_axi_awvalid), 64'(len[31:2] != 30'd0));
        chk("start_busy", 64'(o_busy), 64'(len[31:2] != 30'd0));
        chk("start_done", 64'(o_write_done), 64'(len[31:2] == 30'd0));
        chk("start_err_clr", 64'(o_write_err), 64'd0);
    endtask

    task automatic run_xfer(input logic [31:0] dst, input logic [31:0] len, input int err_b, input int st);
        int d0 = done_cnt;
        int t = 0;
        stall_at = st;
        load(dst, len, err_b);
        start(dst, len);
        while (done_cnt == d0 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", 64'(done_cnt - d0), 64'd1);
        repeat (3) @(negedge clk);
        chk("pop_count", 64'(pop_cnt), 64'(len[31:2]));
    endtask

    initial begin
        int t;
        reset_n = 1'b0; i_start = 1'b0; i_dst_addr = 32'h0; i_total_len = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_awvalid", 64'(m_axi_awvalid), 64'd0);
        chk("rst_wvalid", 64'(m_axi_wvalid), 64'd0);
        chk("rst_bready", 64'(m_axi_bready), 64'd0);
        chk("rst_flags", 64'({o_write_done, o_write_err, o_busy, o_fifo_pop, m_axi_wlast}), 64'd0);
        chk("rst_aw", 64'({m_axi_awaddr, m_axi_awlen}), 64'd0);
        chk("rst_consts", 64'({m_axi_awsize, m_axi_awburst, m_axi_wstrb}), 64'({3'b010, 2'b01, 4'hF}));
        @(posedge clk); #1;
        reset_n = 1'b1;

        run_xfer(32'h1000_0000, 32'd64, -1, -1);   // single burst
        run_xfer(32'h2000_0000, 32'd256, -1, -1);  // four bursts
        run_xfer(32'h0000_0FF8, 32'd32, -1, -1);   // 4 KB split 2 + 6
        run_xfer(32'h0000_0100, 32'd16, -1, 2);    // FIFO stall after beat 2
        run_xfer(32'h4000_0000, 32'd128, 0, -1);   // SLVERR on burst 1 of 2
        run_xfer(32'h5000_0000, 32'd8, -1, -1);    // error cleared by start
        run_xfer(32'h6000_0000, 32'd0, -1, -1);    // zero length
        run_xfer(32'h6000_0000, 32'd3, -1, -1);    // low bits ignored

        rnd_mode = 1'b1;
        for (int i = 0; i < 12; i++)
            run_xfer((32'($urandom) & 32'hFFFF_F000) | (32'($urandom_range(960, 1023)) << 2),
                     32'($urandom_range(0, 300)), int'($urandom_range(0, 3)) - 1, -1);
        rnd_mode = 1'b0;

        // Reset in the middle of the data phase.
        stall_at = -1;
        load(32'h3000_0000, 32'd64, -1);
        start(32'h3000_0000, 32'd64);
        t = 0;
        while (pop_cnt < 3 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("mid_reached", 64'(pop_cnt >= 3), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_valids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 64'd0);
        chk("mid_rst_busy", 64'(o_busy), 64'd0);
        @(posedge clk); #2;
        exp_aw.delete(); exp_w.delete(); exp_done.delete(); fifo_q.delete();
        b_pending = 0; m_axi_bvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        run_xfer(32'h7000_0FC0, 32'd100, -1, -1);  // recovery after reset

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
